serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial, LSB-first ripple adder that computes the sum of two WIDTH-bit unsigned operands plus a carry-in, one bit per clock.
- It is the addition counterpart to the team's combinational subtractor cells.
- Intended for area-constrained datapaths, where a single full-adder cell plus a carry flip-flop replaces a WIDTH-bit parallel adder.
- A start/busy/done handshake lets a controller launch an operation and collect the registered result.

Parameters:
- WIDTH, 8, operand and sum width in bits. Legal range 2..32.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  request a new addition; sampled only when not busy
- a  input  WIDTH  operand A, captured on the accepted start cycle
- b  input  WIDTH  operand B, captured on the accepted start cycle
- cin  input  1  carry-in, captured on the accepted start cycle
- busy  output  1  high while an addition is in progress
- done  output  1  single-cycle pulse; result valid
- sum  output  WIDTH  registered result (a + b + cin) mod 2^WIDTH
- cout  output  1  registered carry-out of the MSB

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: busy=0, done=0, sum=0, cout=0, FSM=IDLE. Internal shift registers, carry FF and bit counter are cleared.
- FSM states:
  - IDLE: busy=0.
    - start=1 -> load a/b into operand shift registers, load carry FF with cin, clear counter, go to RUN.
  - RUN: busy=1. Each cycle:
    - Full add: s = A[0]^B[0]^c; c' = A[0]&B[0] | c&(A[0]^B[0]).
    - Shift s into the MSB of the internal result shift register; shift both operand registers right by 1; update the carry FF; counter++.
    - When counter reaches WIDTH-1 (the WIDTH-th bit processed), go to DONE.
    - The final shift result is copied into sum, and c' into cout, on that same edge.
  - DONE: busy=0, done=1 for exactly one cycle.
    - start=1 in DONE is accepted exactly as in IDLE (back-to-back), going to RUN; otherwise go to IDLE.
- Latency: start accepted at edge 0; busy high for cycles 1..WIDTH; done high in cycle WIDTH+1. Back-to-back throughput is one result per WIDTH+1 cycles.
- Output stability:
  - sum/cout change only on the edge that enters DONE.
  - They hold the last result through IDLE and through any following RUN until the next completion.
- start while busy=1 is ignored. No queuing, no effect on the operation in flight.
- a, b and cin are don't-care except on the accepted start cycle.
- Arithmetic: unsigned; overflow is reported only via cout. Signed users interpret sum as two's complement and derive overflow externally.
- Reset mid-operation: immediate abort. All outputs return to their reset values and no done pulse is produced.
- Counter width: clog2(WIDTH) bits. No wrap beyond WIDTH-1.

Test Plan:
- Reset, then a=0x05, b=0x03, cin=0, start pulse -> busy high for 8 cycles; done pulses in cycle 9; sum=0x08, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Operation in flight with a=0x10, b=0x20; start re-asserted with a=0xAA, b=0x55 during RUN -> ignored; result sum=0x30, cout=0, exactly one done pulse.
- start held high across DONE with a=0x7F, b=0x01 -> second op begins the cycle after done; sum stays 0x30 until the second done, then becomes 0x80, cout=0.
- rst_n asserted low in RUN cycle 4 -> busy, done, sum and cout go to 0 immediately (asynchronous); no done afterwards. A new start after release completes normally.
- Random regression: 1000 random a, b, cin values, checked against (a+b+cin) on {cout,sum}.

Source files
------------

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//   Bit-serial, LSB-first adder: sum = (a + b + cin) mod 2^WIDTH, cout = carry
//   out of the MSB. One full-adder cell and a carry flip-flop process one bit
//   per clock. Handshake: start accepted while idle or on the done cycle,
//   busy high for WIDTH cycles, then a one-cycle done pulse with the result.
//
// Ports
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   launch request (ignored while busy)
//   a, b   in   WIDTH-bit operands, captured on the accepted start cycle
//   cin    in   carry-in, captured on the accepted start cycle
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse, sum/cout hold the new result
//   sum    out  registered WIDTH-bit result
//   cout   out  registered carry-out
// ---------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sr_reg, b_sr_reg, res_sr_reg, sum_reg;
  logic             carry_reg, cout_reg;
  logic [CW-1:0]    cnt_reg;

  logic             accept;
  logic             bit_s, bit_c;
  logic             last_bit;
  logic [WIDTH-1:0] res_shifted;

  // Single full-adder cell working on the current LSBs.
  assign bit_s       = a_sr_reg[0] ^ b_sr_reg[0] ^ carry_reg;
  assign bit_c       = (a_sr_reg[0] & b_sr_reg[0]) | (carry_reg & (a_sr_reg[0] ^ b_sr_reg[0]));
  // Result bits enter at the MSB, so after WIDTH shifts bit 0 sits at bit 0.
  assign res_shifted = {bit_s, res_sr_reg[WIDTH-1:1]};
  assign last_bit    = (cnt_reg == CW'(WIDTH - 1));

  assign sum  = sum_reg;
  assign cout = cout_reg;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (last_bit) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        // Back-to-back launch is accepted exactly as from idle.
        if (start) begin
          accept     = 1'b1;
          state_next = S_RUN;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: operand shifters, carry FF, bit counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_reg   <= '0;
      b_sr_reg   <= '0;
      res_sr_reg <= '0;
      sum_reg    <= '0;
      carry_reg  <= 1'b0;
      cout_reg   <= 1'b0;
      cnt_reg    <= '0;
    end else if (accept) begin
      a_sr_reg  <= a;
      b_sr_reg  <= b;
      carry_reg <= cin;
      cnt_reg   <= '0;
    end else if (busy) begin
      a_sr_reg   <= a_sr_reg >> 1;
      b_sr_reg   <= b_sr_reg >> 1;
      carry_reg  <= bit_c;
      res_sr_reg <= res_shifted;
      if (last_bit) begin
        // Publish on the edge entering DONE; held until the next completion.
        sum_reg  <= res_shifted;
        cout_reg <= bit_c;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int n_checks = 0;
  int n_pass   = 0;
  logic check_en = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Behavioural model: timeline of an accepted operation.
  // phase 0 = free, 1..W = busy cycles, W+1 = done cycle.
  int         m_phase;
  logic [W:0] m_pending;
  logic [W-1:0] m_sum;
  logic       m_cout;
  int         m_accepts = 0;
  logic       m_busy, m_done;

  assign m_busy = (m_phase >= 1) && (m_phase <= W);
  assign m_done = (m_phase == W + 1);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_sum   <= '0;
      m_cout  <= 1'b0;
    end else begin
      if (m_phase >= 1 && m_phase < W) begin
        m_phase <= m_phase + 1;
      end else if (m_phase == W) begin
        m_phase <= W + 1;
        m_sum   <= m_pending[W-1:0];
        m_cout  <= m_pending[W];
      end else if (start) begin
        m_pending <= {1'b0, a} + {1'b0, b} + (W+1)'(cin);
        m_phase   <= 1;
        m_accepts <= m_accepts + 1;
      end else begin
        m_phase <= 0;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      check("cycle {busy,done,cout,sum}", {52'd0, busy, done, cout, sum},
            {52'd0, m_busy, m_done, m_cout, m_sum});
    end
  end

  // Launch one operation (called at posedge+2) and follow it to done.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        output int busy_n, output int done_at);
    a = av; b = bv; cin = cv; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    busy_n = 0; done_at = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        done_at = i;
        break;
      end
    end
  endtask

  task automatic align();
    @(posedge clk); #2;
  endtask

  initial begin
    int bn, da, dones, da2;
    int cyc;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    check_en = 1'b1;
    @(negedge clk);
    check("reset outputs", {busy, done, cout, sum}, 11'd0);
    align();
    rst_n = 1'b1;
    align();

    // 5 + 3
    run_op(8'h05, 8'h03, 1'b0, bn, da);
    check("op1 busy cycles", bn, 8);
    check("op1 done cycle", da, 9);
    check("op1 sum", sum, 8'h08);
    check("op1 cout", cout, 1'b0);
    align();

    run_op(8'hFF, 8'h01, 1'b0, bn, da);
    check("ff+01 {cout,sum}", {cout, sum}, 9'h100);
    align();
    run_op(8'hFF, 8'hFF, 1'b1, bn, da);
    check("ff+ff+1 {cout,sum}", {cout, sum}, 9'h1FF);
    align();

    // start during RUN is ignored
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    align();
    start = 1'b0;
    dones = 0;
    for (int i = 1; i <= W + 6; i++) begin
      @(negedge clk);
      if (done) dones++;
      if (i == 3) begin a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1; end
      if (i == 5) start = 1'b0;
    end
    check("ignored start done count", dones, 1);
    check("ignored start {cout,sum}", {cout, sum}, 9'h030);
    align();

    // back-to-back: start held through DONE
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    align();
    a = 8'h7F; b = 8'h01; cin = 1'b0;
    da = 0; da2 = 0;
    for (int i = 1; i <= 2 * W + 6; i++) begin
      @(negedge clk);
      if (done && da == 0) begin
        da = i;
        check("b2b first sum", sum, 8'h30);
      end else if (done && da2 == 0) begin
        da2 = i;
      end
      if (i == 10) begin
        check("b2b busy after done", busy, 1'b1);
        check("b2b sum held", sum, 8'h30);
        start = 1'b0;
      end
      if (da2 != 0) break;
    end
    check("b2b first done cycle", da, 9);
    check("b2b second done cycle", da2, 18);
    check("b2b second {cout,sum}", {cout, sum}, 9'h080);
    align();

    // asynchronous reset in RUN cycle 4
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    align();
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre-reset busy", busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("async reset outputs", {busy, done, cout, sum}, 11'd0);
    align();
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("no done after reset", dones, 0);
    align();
    run_op(8'h21, 8'h42, 1'b1, bn, da);
    check("post-reset done cycle", da, 9);
    check("post-reset {cout,sum}", {cout, sum}, 9'h064);
    align();

    // random regression, start toggled randomly (including while busy)
    cyc = m_accepts + 1000;
    for (int i = 0; i < 40000 && m_accepts < cyc; i++) begin
      a     = W'($urandom);
      b     = W'($urandom);
      cin   = 1'($urandom);
      start = ($urandom_range(0, 3) != 0);
      align();
    end
    start = 1'b0;
    repeat (W + 3) @(posedge clk);
    #2;
    check_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
